// File: rtl/hv_seq_ctrl.sv
// hv_seq_ctrl: run sequencer for the hypervector datapath.
//
// A start pulse latches the job configuration and then walks four phases:
//   FILL  - drives matw/mat_a to fill the item memory (item_num+1 writes)
//   RUN   - accepts (addr_i+1)*(addr_j+1) source beats and emits the
//           exec/last_j/s_fin strobes, one cycle after each beat
//   DRAIN - holds run until dst_ctrl has streamed out its results
//   IDLE  - reports done (or aborted) and waits for the next start
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN : clock, asynchronous active-low reset
//   start, abort            : single-cycle job control requests
//   item_num                : last item-memory index
//   addr_i, addr_j          : last row index, last beat index within a row
//   src_valid, src_ready    : source stream handshake (S_AXIS_TVALID/TREADY)
//   src_v                   : accepted source beat (combinational)
//   dst_busy                : dst_ctrl still has results to stream
//   matw, mat_a             : item-memory write phase and write address
//   run                     : compute phase active (RUN or DRAIN)
//   exec, last_j, s_fin     : core execute / row-complete / job-final strobes
//   busy, done, aborted     : job status (done and aborted are sticky)
module hv_seq_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned ITEM_W = 16
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic [ITEM_W-1:0] item_num,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] addr_j,
  input  logic              src_valid,
  input  logic              dst_busy,
  output logic              src_ready,
  output logic              src_v,
  output logic              matw,
  output logic [ITEM_W-1:0] mat_a,
  output logic              run,
  output logic              exec,
  output logic              last_j,
  output logic              s_fin,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ITEM_W-1:0] item_q, item_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d;
  logic [ADDR_W-1:0] addr_j_q, addr_j_d;
  logic [ADDR_W-1:0] i_cnt, i_d;
  logic [ADDR_W-1:0] j_cnt, j_d;
  logic [ITEM_W-1:0] mat_a_d;
  logic              drain_min, drain_min_d;
  logic              matw_d, run_d, src_ready_d;
  logic              exec_d, last_j_d, s_fin_d;
  logic              busy_d, done_d, aborted_d;
  logic              row_end, job_end;

  // src_ready is only ever high in RUN, so src_v alone qualifies a beat.
  assign src_v   = src_valid & src_ready;
  assign row_end = (j_cnt == addr_j_q);
  assign job_end = row_end && (i_cnt == addr_i_q);

  always_comb begin
    state_d     = state;
    item_d      = item_q;
    addr_i_d    = addr_i_q;
    addr_j_d    = addr_j_q;
    i_d         = i_cnt;
    j_d         = j_cnt;
    mat_a_d     = mat_a;
    drain_min_d = drain_min;
    matw_d      = 1'b0;
    run_d       = 1'b0;
    src_ready_d = 1'b0;
    exec_d      = 1'b0;
    last_j_d    = 1'b0;
    s_fin_d     = 1'b0;
    done_d      = done;
    aborted_d   = aborted;

    if ((state != IDLE) && abort) begin
      state_d     = IDLE;
      i_d         = '0;
      j_d         = '0;
      mat_a_d     = '0;
      drain_min_d = 1'b0;
      done_d      = 1'b0;
      aborted_d   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          // abort alongside start wins: the job never begins
          if (start && !abort) begin
            item_d    = item_num;
            addr_i_d  = addr_i;
            addr_j_d  = addr_j;
            i_d       = '0;
            j_d       = '0;
            mat_a_d   = '0;
            done_d    = 1'b0;
            aborted_d = 1'b0;
            matw_d    = 1'b1;
            state_d   = FILL;
          end
        end

        FILL: begin
          if (mat_a == item_q) begin
            mat_a_d     = '0;
            run_d       = 1'b1;
            src_ready_d = 1'b1;
            state_d     = RUN;
          end else begin
            mat_a_d = mat_a + ITEM_W'(1);
            matw_d  = 1'b1;
          end
        end

        RUN: begin
          run_d       = 1'b1;
          src_ready_d = 1'b1;
          if (src_v) begin
            exec_d = 1'b1;
            if (row_end) begin
              last_j_d = 1'b1;
              j_d      = '0;
              if (job_end) begin
                // final beat: ready drops next cycle so no extra beat slips in
                s_fin_d     = 1'b1;
                i_d         = '0;
                src_ready_d = 1'b0;
                drain_min_d = 1'b0;
                state_d     = DRAIN;
              end else begin
                i_d = i_cnt + ADDR_W'(1);
              end
            end else begin
              j_d = j_cnt + ADDR_W'(1);
            end
          end
        end

        DRAIN: begin
          run_d = 1'b1;
          // drain_min guarantees two DRAIN cycles so dst_ctrl can react to
          // s_fin before its dst_busy is trusted
          if (drain_min && !dst_busy) begin
            run_d       = 1'b0;
            done_d      = 1'b1;
            drain_min_d = 1'b0;
            state_d     = IDLE;
          end else begin
            drain_min_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state     <= IDLE;
      item_q    <= '0;
      addr_i_q  <= '0;
      addr_j_q  <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      mat_a     <= '0;
      drain_min <= 1'b0;
      matw      <= 1'b0;
      run       <= 1'b0;
      src_ready <= 1'b0;
      exec      <= 1'b0;
      last_j    <= 1'b0;
      s_fin     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_d;
      item_q    <= item_d;
      addr_i_q  <= addr_i_d;
      addr_j_q  <= addr_j_d;
      i_cnt     <= i_d;
      j_cnt     <= j_d;
      mat_a     <= mat_a_d;
      drain_min <= drain_min_d;
      matw      <= matw_d;
      run       <= run_d;
      src_ready <= src_ready_d;
      exec      <= exec_d;
      last_j    <= last_j_d;
      s_fin     <= s_fin_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
    end
  end

endmodule

// File: tb/tb_hv_seq_ctrl.sv
// Testbench for hv_seq_ctrl: table of full jobs checked cycle by cycle
// against a small phase model plus hand-computed strobe counts, followed by
// directed abort, start/abort-collision and mid-fill reset sequences.
module tb_hv_seq_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned IW = 16;

  localparam int P_FILL  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          AXIS_ACLK;
  logic          AXIS_ARESETN;
  logic          start, abort;
  logic [IW-1:0] item_num;
  logic [AW-1:0] addr_i, addr_j;
  logic          src_valid, dst_busy;
  logic          src_ready, src_v, matw;
  logic [IW-1:0] mat_a;
  logic          run, exec, last_j, s_fin, busy, done, aborted;

  hv_seq_ctrl #(.ADDR_W(AW), .ITEM_W(IW)) dut (
    .AXIS_ACLK   (AXIS_ACLK),
    .AXIS_ARESETN(AXIS_ARESETN),
    .start       (start),
    .abort       (abort),
    .item_num    (item_num),
    .addr_i      (addr_i),
    .addr_j      (addr_j),
    .src_valid   (src_valid),
    .dst_busy    (dst_busy),
    .src_ready   (src_ready),
    .src_v       (src_v),
    .matw        (matw),
    .mat_a       (mat_a),
    .run         (run),
    .exec        (exec),
    .last_j      (last_j),
    .s_fin       (s_fin),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  initial AXIS_ACLK = 1'b0;
  always #5 AXIS_ACLK = ~AXIS_ACLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned item;
    int unsigned ai;
    int unsigned aj;
    bit          toggle;
    int unsigned hold;
    int unsigned e_matw;
    int unsigned e_exec;
    int unsigned e_lastj;
    int unsigned e_sfin;
    int unsigned e_drain;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXIS_ACLK);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({src_ready, src_v, matw, mat_a, run, exec, last_j, s_fin, busy, done, aborted});
  endfunction

  // Runs one complete job, comparing every cycle against a phase model.
  task automatic do_job(input vec_t v, input string tag);
    int ph, mm, mi, mj, dcnt, bh, cyc, errs;
    int matw_n, exec_n, lastj_n, sfin_n, drain_n;
    bit me, ml, ms, sv, beat;
    ph = P_FILL; mm = 0; mi = 0; mj = 0; dcnt = 0; bh = 0; cyc = 0; errs = 0;
    matw_n = 0; exec_n = 0; lastj_n = 0; sfin_n = 0; drain_n = 0;
    me = 0; ml = 0; ms = 0;

    item_num  = IW'(v.item);
    addr_i    = AW'(v.ai);
    addr_j    = AW'(v.aj);
    src_valid = 1'b0;
    dst_busy  = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    // live config changes mid-job must have no effect
    item_num = '1;
    addr_i   = AW'(3);
    addr_j   = AW'(5);

    while (ph != P_DONE && cyc < 5000) begin
      if (matw !== (ph == P_FILL))                       errs++;
      if (mat_a !== ((ph == P_FILL) ? IW'(mm) : IW'(0))) errs++;
      if (src_ready !== (ph == P_RUN))                   errs++;
      if (run !== (ph == P_RUN || ph == P_DRAIN))        errs++;
      if (exec !== me || last_j !== ml || s_fin !== ms)  errs++;
      if (busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) errs++;
      if (matw)   matw_n++;
      if (exec)   exec_n++;
      if (last_j) lastj_n++;
      if (s_fin)  sfin_n++;
      if (run && !src_ready) drain_n++;

      sv = v.toggle ? (cyc % 2 == 0) : 1'b1;
      src_valid = sv;
      if (ms) bh = v.hold;
      dst_busy = (bh > 0);
      if (bh > 0) bh--;
      #1;
      beat = sv && (ph == P_RUN);
      if (src_v !== beat) errs++;

      case (ph)
        P_FILL: begin
          if (mm == int'(v.item)) begin ph = P_RUN; mm = 0; end
          else mm++;
        end
        P_RUN: begin
          me = beat;
          ml = beat && (mj == int'(v.aj));
          ms = ml && (mi == int'(v.ai));
          if (beat) begin
            if (mj == int'(v.aj)) begin
              mj = 0;
              if (mi == int'(v.ai)) begin mi = 0; ph = P_DRAIN; dcnt = 0; end
              else mi++;
            end else mj++;
          end
        end
        P_DRAIN: begin
          me = 0; ml = 0; ms = 0;
          if (dcnt >= 1 && !dst_busy) ph = P_DONE;
          else dcnt++;
        end
        default: ;
      endcase
      tick();
      cyc++;
    end
    src_valid = 1'b0;
    dst_busy  = 1'b0;

    chk({tag, "_timeout"}, 32'(cyc < 5000), 1);
    chk({tag, "_cycle_model"}, errs, 0);
    chk({tag, "_matw_cycles"}, matw_n, v.e_matw);
    chk({tag, "_exec_count"}, exec_n, v.e_exec);
    chk({tag, "_last_j_count"}, lastj_n, v.e_lastj);
    chk({tag, "_s_fin_count"}, sfin_n, v.e_sfin);
    chk({tag, "_drain_cycles"}, drain_n, v.e_drain);
    chk({tag, "_final_status"}, 32'({done, busy, run, src_ready, aborted}), 32'b10000);
  endtask

  initial begin
    int errs, beats, cyc;

    vecs[0] = '{item: 99, ai: 7, aj: 2, toggle: 0, hold: 0,  e_matw: 100, e_exec: 24, e_lastj: 8, e_sfin: 1, e_drain: 2};
    vecs[1] = '{item: 99, ai: 7, aj: 2, toggle: 1, hold: 10, e_matw: 100, e_exec: 24, e_lastj: 8, e_sfin: 1, e_drain: 11};
    vecs[2] = '{item: 0,  ai: 0, aj: 0, toggle: 0, hold: 0,  e_matw: 1,   e_exec: 1,  e_lastj: 1, e_sfin: 1, e_drain: 2};
    vecs[3] = '{item: 3,  ai: 2, aj: 0, toggle: 1, hold: 3,  e_matw: 4,   e_exec: 3,  e_lastj: 3, e_sfin: 1, e_drain: 4};
    vecs[4] = '{item: 5,  ai: 0, aj: 4, toggle: 0, hold: 0,  e_matw: 6,   e_exec: 5,  e_lastj: 1, e_sfin: 1, e_drain: 2};

    AXIS_ARESETN = 1'b0;
    start = 1'b0; abort = 1'b0;
    item_num = '0; addr_i = '0; addr_j = '0;
    src_valid = 1'b0; dst_busy = 1'b0;
    repeat (2) @(posedge AXIS_ACLK);
    #1;
    chk("reset_outputs", all_outs(), 0);
    AXIS_ARESETN = 1'b1;
    tick();

    // start together with abort in IDLE: abort wins
    item_num = IW'(3); start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'({busy, matw, aborted, done}), 0);

    for (int k = 0; k < 5; k++) do_job(vecs[k], $sformatf("vec%0d", k));

    // abort after beat 10 of the 24-beat job
    item_num = IW'(4); addr_i = AW'(7); addr_j = AW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!src_ready && cyc < 200) begin tick(); cyc++; end
    chk("abort_reach_run", 32'(src_ready), 1);
    beats = 0;
    cyc = 0;
    while (beats < 10 && cyc < 200) begin
      src_valid = 1'b1;
      #1;
      if (src_v) beats++;
      tick();
      cyc++;
    end
    chk("abort_beats_before", beats, 10);
    src_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_status", 32'({busy, run, src_ready, matw, done, aborted}), 32'b000001);
    errs = 0;
    src_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (exec || last_j || s_fin || src_v || busy || matw || run) errs++;
      tick();
    end
    src_valid = 1'b0;
    chk("abort_quiet", errs, 0);
    do_job(vecs[0], "after_abort");

    // reset during FILL at mat_a=40, with an ignored start while busy
    item_num = IW'(99); addr_i = AW'(7); addr_j = AW'(2);
    start = 1'b1;
    tick();
    errs = 0;
    for (int k = 0; k <= 40; k++) begin
      if (mat_a !== IW'(k) || matw !== 1'b1) errs++;
      start    = (k == 20);
      item_num = (k == 20) ? IW'(5) : IW'(99);
      if (k < 40) tick();
    end
    start = 1'b0;
    chk("fill_ignores_start", errs, 0);
    chk("fill_mat_a_40", 32'(mat_a), 40);
    #1;
    AXIS_ARESETN = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    src_valid = 1'b1;
    tick();
    AXIS_ARESETN = 1'b1;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (all_outs() !== 32'd0) errs++;
    end
    chk("post_reset_quiet", errs, 0);
    src_valid = 1'b0;
    item_num = IW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_fill_0", 32'({matw, mat_a}), 32'({1'b1, IW'(0)}));
    tick();
    chk("restart_fill_1", 32'({matw, mat_a}), 32'({1'b1, IW'(1)}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
